tx_buffer_fifo: RTL and testbench

//   Transmit-side byte buffer feeding the link's Tx_Buffer/VALID input ahead of the control mux and byte striping.

---
 rtl/tx_buffer_fifo.sv | 118 +++++++++++
 tb/tb_tx_buffer_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tx_buffer_fifo.sv
// rtl/tx_buffer_fifo.sv - transmit byte FIFO with registered read port, watermarks and sticky errors
// Optional TX_FIFO_IDLE_FILL_EN: pop on empty drives the idle symbol 8'hBC instead of flagging underflow.
module tx_buffer_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);
`ifdef TX_FIFO_IDLE_FILL_EN
  localparam logic [DATA_W-1:0] IDLE_SYM = DATA_W'(8'hBC);
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push_ok, pop_ok;

  // Acceptance looks only at registered count; a full FIFO can take a push when a pop frees a slot.
  always_comb begin
    pop_ok      = pop && (count_q != '0);
    push_ok     = push && ((count_q != DEPTH_C) || pop_ok);
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else if (push) begin
      overflow_d = 1'b1;
    end

    if (pop_ok) begin
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end else if (pop) begin
`ifdef TX_FIFO_IDLE_FILL_EN
      data_out_d = IDLE_SYM;
`else
      underflow_d = 1'b1;
`endif
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: contents are unreachable until rewritten.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign data_out      = data_out_q;
  assign valid_out     = valid_out_q;
  assign count         = count_q;
  assign full          = (count_q == DEPTH_C);
  assign empty         = (count_q == '0);
  assign almost_full   = (count_q >= AF_C);
  assign almost_empty  = (count_q <= AE_C);
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_tx_buffer_fifo.sv
// tb/tb_tx_buffer_fifo.sv - scoreboard bench for tx_buffer_fifo
module tb_tx_buffer_fifo;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       push = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       pop = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow_err, underflow_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  logic       exp_of = 1'b0;
  logic       exp_uf = 1'b0;

  always #500 CLK = ~CLK;

  tx_buffer_fifo dut (
    .CLK(CLK), .RESET(RESET), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid byte must match the oldest outstanding expected byte.
  always @(negedge CLK) begin
    if (!RESET && valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got %0h expected no output at %0t", data_out, $time);
      end else begin
        chk("data_out", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic check_flags();
    chk("count", count, model.size());
    chk("full", full, model.size() == 8);
    chk("empty", empty, model.size() == 0);
    chk("almost_full", almost_full, model.size() >= 6);
    chk("almost_empty", almost_empty, model.size() <= 2);
    chk("overflow_err", overflow_err, exp_of);
    chk("underflow_err", underflow_err, exp_uf);
  endtask

  // One clock of stimulus; inputs change on the falling edge, results sampled on the next one.
  task automatic cyc(input logic p, input logic [7:0] d, input logic r);
    logic pop_ok, push_ok;
    pop_ok  = r && (model.size() > 0);
    push_ok = p && ((model.size() < 8) || pop_ok);
    if (pop_ok) exp_q.push_back(model.pop_front());
    if (push_ok) model.push_back(d);
    if (p && !push_ok) exp_of = 1'b1;
`ifndef TX_FIFO_IDLE_FILL_EN
    if (r && !pop_ok) exp_uf = 1'b1;
`endif
    push = p; data_in = d; pop = r;
    @(negedge CLK);
    push = 1'b0; pop = 1'b0;
    chk("valid_out", valid_out, pop_ok);
`ifdef TX_FIFO_IDLE_FILL_EN
    if (r && !pop_ok) chk("idle_fill", data_out, 8'hBC);
`endif
    check_flags();
  endtask

  task automatic do_reset(input logic p);
    RESET = 1'b1; push = p; data_in = 8'h99;
    @(negedge CLK);
    RESET = 1'b0; push = 1'b0;
    model.delete();
    exp_q.delete();
    exp_of = 1'b0;
    exp_uf = 1'b0;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    check_flags();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge CLK);
    do_reset(1'b0);

    // 1: three bytes in, three out
    cyc(1, 8'hA1, 0); cyc(1, 8'hB2, 0); cyc(1, 8'hC3, 0);
    chk("t1_count3", count, 3);
    cyc(0, 0, 1); chk("t1_a1", data_out, 8'hA1);
    cyc(0, 0, 1); chk("t1_b2", data_out, 8'hB2);
    cyc(0, 0, 1); chk("t1_c3", data_out, 8'hC3);
    chk("t1_count0", count, 0);

    // 2: fill, overflow, drain in order
    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'(i), 0);
      chk("t2_af", almost_full, (i + 1) >= 6);
    end
    chk("t2_full", full, 1);
    cyc(1, 8'hFF, 0);
    chk("t2_ovf", overflow_err, 1);
    chk("t2_count", count, 8);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      chk("t2_order", data_out, i);
    end

    // 3: full with simultaneous push and pop
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'hEE, 1);
    chk("t3_dout", data_out, 8'h00);
    chk("t3_count", count, 8);
    chk("t3_ovf", overflow_err, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1);
    chk("t3_last", data_out, 8'hEE);

    // 4: push and pop together on empty
    do_reset(1'b0);
    cyc(1, 8'h55, 1);
    chk("t4_count", count, 1);
    chk("t4_valid", valid_out, 0);
`ifdef TX_FIFO_IDLE_FILL_EN
    chk("t4_idle", data_out, 8'hBC);
    chk("t4_uf", underflow_err, 0);
`else
    chk("t4_uf", underflow_err, 1);
`endif
    cyc(0, 0, 1);
    chk("t4_55", data_out, 8'h55);

    // 5: pointer wrap with interleaved pushes
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) cyc(1, 8'h10 + 8'(i), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(i % 2 == 0, 8'h20 + 8'(i), 1);
      chk("t5_range", count <= 8, 1);
    end
    chk("t5_empty", empty, 1);

    // 6: reset with push pending discards state and errors
    do_reset(1'b0);
    cyc(0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(1, 8'h30 + 8'(i), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    chk("t6_count5", count, 5);
    chk("t6_ovf_set", overflow_err, 1);
    do_reset(1'b1);
    chk("t6_count0", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ovf", overflow_err, 0);
    chk("t6_uf", underflow_err, 0);
    cyc(0, 0, 1);
    chk("t6_empty_pop", valid_out, 0);

    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
